bullet_engine: RTL and testbench



---
 rtl/bullet_pkg.sv | 34 +++
 rtl/bullet_step_timer.sv | 27 ++
 rtl/bullet_engine.sv | 211 +++++++++++++++++++++
 tb/tb_bullet_engine.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bullet_pkg.sv
// Shared types and constants for the tank-game projectile engine.
package bullet_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_STEP,
    S_CHECK,
    S_EVAL,
    S_BURST
  } state_t;

  localparam logic [1:0] MAP_OBSTRUCTION = 2'b10;
  localparam logic [7:0] WORLD_MAX       = 8'd127;

  // Indexed by heading; element 0 is N, element 7 is NW.
  localparam logic [7:0][7:0] DX_TBL = {
    8'hFF, 8'hFF, 8'hFF, 8'h00,
    8'h01, 8'h01, 8'h01, 8'h00
  };
  localparam logic [7:0][7:0] DY_TBL = {
    8'hFF, 8'h00, 8'h01, 8'h01,
    8'h01, 8'h00, 8'hFF, 8'hFF
  };

  function automatic logic [7:0] absdiff(
    input logic [7:0] a,
    input logic [7:0] b
  );
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/bullet_step_timer.sv
// Loadable down-counter with a done pulse while enabled at zero.
module bullet_step_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = i_en && (r_cnt == '0);

endmodule

// File: rtl/bullet_engine.sv
// Bullet launch/step/hit engine for the two-bot tank game.
// Wall collision via the map port is enabled by BULLET_WALL_CHECK_EN.
module bullet_engine
  import bullet_pkg::*;
#(
  parameter int STEP_DIV     = 750000,
  parameter int MAX_RANGE    = 64,
  parameter int BURST_CYCLES = 37500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fire,
  input  logic [7:0]  LocX_reg,
  input  logic [7:0]  LocY_reg,
  input  logic [7:0]  BotInfo_reg,
  input  logic [7:0]  OppX_reg,
  input  logic [7:0]  OppY_reg,
  output logic [13:0] map_addr,
  input  logic [1:0]  map_data,
  input  logic [11:0] pixel_row,
  input  logic [11:0] pixel_column,
  output logic        bullet,
  output logic        active,
  output logic        burst,
  output logic        hit,
  output logic [7:0]  hit_count
);

  // Timer is widened beyond 24 bits when the burst hold needs it.
  localparam int MAXC  = (STEP_DIV > BURST_CYCLES) ? STEP_DIV : BURST_CYCLES;
  localparam int TMR_W = ($clog2(MAXC) > 24) ? $clog2(MAXC) : 24;
  localparam int BLD   = (BURST_CYCLES > 0) ? BURST_CYCLES - 1 : 0;
  localparam logic [TMR_W-1:0] STEP_LD  = TMR_W'(STEP_DIV - 1);
  localparam logic [TMR_W-1:0] BURST_LD = TMR_W'(BLD);

  state_t r_state;
  state_t w_nxt;

  logic       r_fire_q;
  logic       r_arm;
  logic       r_rise;
  logic [6:0] r_bul_x;
  logic [6:0] r_bul_y;
  logic [2:0] r_hdg;
  logic [7:0] r_range;
  logic       r_bullet;
  logic       r_hit;
  logic [7:0] r_hit_cnt;

  logic [7:0] w_nx;
  logic [7:0] w_ny;
  logic       w_off;
  logic       w_hit;
  logic       w_wall;
  logic       w_rng_done;
  logic       w_active;
  logic       w_tmr_load;
  logic       w_tmr_en;
  logic       w_tmr_done;
  logic [TMR_W-1:0] w_tmr_val;
  logic       w_unused;

  bullet_step_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst        (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (w_tmr_en),
    .o_done     (w_tmr_done)
  );

  assign w_nx = {1'b0, r_bul_x} + DX_TBL[r_hdg];
  assign w_ny = {1'b0, r_bul_y} + DY_TBL[r_hdg];
  // 0-1 wraps to 255, so one compare covers both map edges.
  assign w_off = (w_nx > WORLD_MAX) || (w_ny > WORLD_MAX);

  assign w_hit =
    (absdiff({1'b0, r_bul_x}, OppX_reg) <= 8'd1) &&
    (absdiff({1'b0, r_bul_y}, OppY_reg) <= 8'd1);

  assign w_rng_done = (r_range == 8'(MAX_RANGE));

`ifdef BULLET_WALL_CHECK_EN
  logic [13:0] r_map_addr;
  assign w_wall   = (map_data == MAP_OBSTRUCTION);
  assign map_addr = r_map_addr;
  assign w_unused = &{1'b0, LocX_reg[7], LocY_reg[7],
                      BotInfo_reg[7:3], pixel_row[11:10],
                      pixel_row[2:0], pixel_column[11:10],
                      pixel_column[2:0]};
`else
  assign w_wall   = 1'b0;
  assign map_addr = '0;
  assign w_unused = &{1'b0, map_data, LocX_reg[7], LocY_reg[7],
                      BotInfo_reg[7:3], pixel_row[11:10],
                      pixel_row[2:0], pixel_column[11:10],
                      pixel_column[2:0]};
`endif

  assign w_active = (r_state == S_LAUNCH) || (r_state == S_WAIT) ||
                    (r_state == S_STEP) || (r_state == S_CHECK) ||
                    (r_state == S_EVAL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt      = r_state;
    w_tmr_load = 1'b0;
    w_tmr_val  = STEP_LD;
    w_tmr_en   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_rise) w_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        w_nxt      = S_WAIT;
        w_tmr_load = 1'b1;
      end
      S_WAIT: begin
        w_tmr_en = 1'b1;
        if (w_tmr_done) w_nxt = S_STEP;
      end
      S_STEP: begin
        w_nxt = w_off ? S_IDLE : S_CHECK;
      end
      S_CHECK: begin
        w_nxt = S_EVAL;
      end
      S_EVAL: begin
        if (w_hit) begin
          w_nxt      = S_BURST;
          w_tmr_load = 1'b1;
          w_tmr_val  = BURST_LD;
        end else if (w_wall || w_rng_done) begin
          w_nxt = S_IDLE;
        end else begin
          w_nxt      = S_WAIT;
          w_tmr_load = 1'b1;
        end
      end
      S_BURST: begin
        w_tmr_en = 1'b1;
        if (w_tmr_done) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // r_arm masks the first sample after reset so a held fire is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fire_q  <= 1'b0;
      r_arm     <= 1'b0;
      r_rise    <= 1'b0;
      r_hit     <= 1'b0;
      r_hit_cnt <= '0;
      r_bullet  <= 1'b0;
    end else begin
      r_fire_q <= fire;
      r_arm    <= 1'b1;
      r_rise   <= fire & ~r_fire_q & r_arm;
      r_hit    <= (r_state == S_EVAL) && w_hit;
      if ((r_state == S_EVAL) && w_hit && (r_hit_cnt != 8'hFF))
        r_hit_cnt <= r_hit_cnt + 1'b1;
      r_bullet <= w_active &&
                  (pixel_column[9:3] == r_bul_x) &&
                  (pixel_row[9:3] == r_bul_y);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bul_x <= '0;
      r_bul_y <= '0;
      r_hdg   <= '0;
      r_range <= '0;
    end else if (r_state == S_LAUNCH) begin
      r_bul_x <= LocX_reg[6:0];
      r_bul_y <= LocY_reg[6:0];
      r_hdg   <= BotInfo_reg[2:0];
      r_range <= '0;
    end else if ((r_state == S_STEP) && !w_off) begin
      r_bul_x <= w_nx[6:0];
      r_bul_y <= w_ny[6:0];
      r_range <= r_range + 1'b1;
    end
  end

`ifdef BULLET_WALL_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_map_addr <= '0;
    end else if ((r_state == S_STEP) && !w_off) begin
      r_map_addr <= {w_ny[6:0], w_nx[6:0]};
    end
  end
`endif

  assign bullet    = r_bullet;
  assign active    = w_active;
  assign burst     = (r_state == S_BURST);
  assign hit       = r_hit;
  assign hit_count = r_hit_cnt;

endmodule

// File: tb/tb_bullet_engine.sv
// Directed table-driven bench for bullet_engine.
module tb_bullet_engine;

  localparam int SD  = 4;
  localparam int MR  = 8;
  localparam int BC  = 10;
  localparam int PER = SD + 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        fire;
  logic [7:0]  LocX_reg, LocY_reg, BotInfo_reg, OppX_reg, OppY_reg;
  logic [13:0] map_addr;
  logic [1:0]  map_data;
  logic [11:0] pixel_row, pixel_column;
  logic        bullet, active, burst, hit;
  logic [7:0]  hit_count;

  int tests = 0;
  int fails = 0;
  int exp_hc = 0;
  int g_wen = 0, g_wx = 0, g_wy = 0;

  bullet_engine #(
    .STEP_DIV(SD), .MAX_RANGE(MR), .BURST_CYCLES(BC)
  ) dut (
    .clk(clk), .reset(reset), .fire(fire),
    .LocX_reg(LocX_reg), .LocY_reg(LocY_reg),
    .BotInfo_reg(BotInfo_reg),
    .OppX_reg(OppX_reg), .OppY_reg(OppY_reg),
    .map_addr(map_addr), .map_data(map_data),
    .pixel_row(pixel_row), .pixel_column(pixel_column),
    .bullet(bullet), .active(active), .burst(burst),
    .hit(hit), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  // One-cycle-latency map RAM holding at most one obstruction.
  always @(posedge clk)
    map_data <= (g_wen != 0 &&
                 map_addr == {7'(g_wy), 7'(g_wx)}) ? 2'b10 : 2'b00;

  typedef struct {
    int lx, ly, hd, ox, oy;
    int wen, wx, wy, px, py;
    int kw, knw, off, hit, pix;
  } vec_t;

  vec_t tv[9];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic setup(input vec_t v);
    LocX_reg     = 8'(v.lx);
    LocY_reg     = 8'(v.ly);
    BotInfo_reg  = 8'(v.hd);
    OppX_reg     = 8'(v.ox);
    OppY_reg     = 8'(v.oy);
    g_wen        = v.wen;
    g_wx         = v.wx;
    g_wy         = v.wy;
    pixel_column = {2'b00, 7'(v.px), 3'b000};
    pixel_row    = {2'b00, 7'(v.py), 3'b000};
  endtask

  task automatic shot(
    input  int refire_at,
    output int act_n, output int hit_n, output int burst_n,
    output int pix_n, output int bad_n
  );
    bit started, done;
    act_n = 0; hit_n = 0; burst_n = 0; pix_n = 0; bad_n = 0;
    started = 0; done = 0;
    fire = 1'b0;
    @(posedge clk); #1;
    fire = 1'b1;
    for (int c = 0; c < 600 && !done; c++) begin
      @(negedge clk);
      if (active) begin act_n++; started = 1; end
      hit_n   += int'(hit);
      burst_n += int'(burst);
      pix_n   += int'(bullet);
      if (map_addr[6:0] == 7'h7F || map_addr[13:7] == 7'h7F) bad_n++;
      if (refire_at >= 0 && c == refire_at) fire = 1'b0;
      if (refire_at >= 0 && c == refire_at + 2) fire = 1'b1;
      if (started && !active && !burst) done = 1;
    end
    if (!done) chk("shot_timeout", 0, 1);
  endtask

  initial begin
    int a, h, b, p, bad, k, ea;
    tv[0] = '{10, 20, 2, 100, 100, 0, 0, 0, 13, 20, 8, 8, 0, 0, 7};
    tv[1] = '{10, 20, 2, 100, 100, 1, 12, 20, 11, 20, 2, 8, 0, 0, 7};
    tv[2] = '{10, 20, 2, 15, 20, 0, 0, 0, 14, 20, 4, 4, 0, 1, 2};
    tv[3] = '{0, 5, 6, 100, 100, 0, 0, 0, 0, 5, 1, 1, 1, 0, 5};
    tv[4] = '{3, 3, 7, 100, 100, 0, 0, 0, 0, 0, 4, 4, 1, 0, 7};
    tv[5] = '{50, 50, 3, 53, 54, 0, 0, 0, 52, 52, 3, 3, 0, 1, 7};
    tv[6] = '{64, 3, 0, 0, 100, 0, 0, 0, 64, 0, 4, 4, 1, 0, 7};
    tv[7] = '{20, 20, 4, 20, 20, 0, 0, 0, 20, 20, 1, 1, 0, 1, 5};
    tv[8] = '{30, 40, 2, 32, 40, 1, 31, 40, 31, 40, 1, 1, 0, 1, 2};

    reset = 1'b1;
    fire  = 1'b0;
    setup(tv[0]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_active", int'(active), 0);
    chk("rst_outs", int'({bullet, burst, hit}), 0);
    chk("rst_hit_count", int'(hit_count), 0);
    chk("rst_map_addr", int'(map_addr), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 9; i++) begin
      setup(tv[i]);
`ifdef BULLET_WALL_CHECK_EN
      k = tv[i].kw;
`else
      k = tv[i].knw;
`endif
      ea = (tv[i].off != 0) ? 1 + (k - 1) * PER + SD + 1 : 1 + k * PER;
      shot(-1, a, h, b, p, bad);
      fire = 1'b0;
      if (tv[i].hit != 0 && exp_hc < 255) exp_hc++;
      chk($sformatf("v%0d_active_cycles", i), a, ea);
      chk($sformatf("v%0d_hit_pulses", i), h, tv[i].hit);
      chk($sformatf("v%0d_burst_cycles", i), b, tv[i].hit * BC);
      chk($sformatf("v%0d_pixel", i), p, tv[i].pix);
      chk($sformatf("v%0d_hit_count", i), int'(hit_count), exp_hc);
      chk($sformatf("v%0d_edge_addr", i), bad, 0);
      repeat (2) @(posedge clk);
    end

    // Refire mid-flight is dropped; held fire does not relaunch.
    setup(tv[0]);
    shot(10, a, h, b, p, bad);
    chk("refire_active_cycles", a, 1 + MR * PER);
    a = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      a += int'(active);
    end
    chk("held_fire_no_launch", a, 0);
    @(posedge clk); #1;
    fire = 1'b0;
    @(posedge clk); #1;
    fire = 1'b1;
    a = 0;
    for (int c = 0; c < 10 && a == 0; c++) begin
      @(negedge clk);
      a = int'(active);
    end
    chk("refire_after_drop", a, 1);
    for (int c = 0; c < 200 && active; c++) @(negedge clk);
    fire = 1'b0;
    repeat (2) @(posedge clk);

    // Saturate the hit counter.
    setup(tv[7]);
    for (int n = 0; n < 260; n++) begin
      shot(-1, a, h, b, p, bad);
      fire = 1'b0;
    end
    chk("hit_count_sat", int'(hit_count), 255);

    // Asynchronous reset while waiting between steps.
    setup(tv[0]);
    pixel_column = {2'b00, 7'd10, 3'b000};
    pixel_row    = {2'b00, 7'd20, 3'b000};
    fire = 1'b0;
    @(posedge clk); #1;
    fire = 1'b1;
    a = 0;
    for (int c = 0; c < 50 && a < 3; c++) begin
      @(negedge clk);
      a += int'(active);
    end
    chk("pre_rst_bullet", int'(bullet), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_active", int'(active), 0);
    chk("mid_rst_bullet", int'(bullet), 0);
    chk("mid_rst_hit_count", int'(hit_count), 0);
    chk("mid_rst_burst_hit", int'({burst, hit}), 0);
    chk("mid_rst_map_addr", int'(map_addr), 0);
    exp_hc = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    a = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      a += int'(active);
    end
    chk("held_fire_at_release", a, 0);
    setup(tv[0]);
    shot(-1, a, h, b, p, bad);
    fire = 1'b0;
    chk("relaunch_active_cycles", a, 1 + MR * PER);
    chk("relaunch_hit_count", int'(hit_count), exp_hc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
